// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM and ALU decoder for a multicycle RISC-V datapath with retired-instruction counter
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal_instr,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_FUNCT} aluop_t;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  state_t           r_state;
  state_t           w_next;
  aluop_t           w_aluop;
  logic             w_retire;
  logic             w_legal;
  logic [CNT_W-1:0] r_instret;
  assign w_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                   (op == OP_I) || (op == OP_BR) || (op == OP_J);
  // Next-state and datapath controls; fetch enables are masked while reset is held
  always_comb begin
    w_next        = S_FETCH;
    w_aluop       = OP_ADD;
    w_retire      = 1'b0;
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    RegWrite      = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready & rst;
        PCWrite   = mem_ready & rst;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b01;
        illegal_instr = ~w_legal;
        w_next        = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                        (op == OP_R)  ? S_EXECUTER :
                        (op == OP_I)  ? S_EXECUTEI :
                        (op == OP_BR) ? S_BEQ :
                        (op == OP_J)  ? S_JAL : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        w_retire  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        w_retire = mem_ready;
        w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        w_aluop = OP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = OP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_retire = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_aluop  = OP_SUB;
        PCWrite  = Zero;
        w_retire = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end
  assign ImmSrc = (op == OP_SW) ? 2'b01 : (op == OP_BR) ? 2'b10 : (op == OP_J) ? 2'b11 : 2'b00;
  assign ALUControl = (w_aluop == OP_SUB) ? 3'b001 :
                      (w_aluop != OP_FUNCT) ? 3'b000 :
                      (funct3 == 3'b000) ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                      (funct3 == 3'b010) ? 3'b101 :
                      (funct3 == 3'b110) ? 3'b011 :
                      (funct3 == 3'b111) ? 3'b010 : 3'b000;
  // State register and retired-instruction counter; illegal DECODE exits never retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end
  assign state_o = r_state;
  assign instret = r_instret;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized scoreboard bench for the multicycle controller
module tb_multicycle_controller;
  bit          clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state_o;
  logic [31:0] instret;
  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } exp_t;
  exp_t        sb[$];
  int          n_chk;
  int          n_fail;
  logic [31:0] cnt;
  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  always #5 clk = ~clk;
  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_instr(illegal_instr),
    .state_o(state_o), .instret(instret)
  );
  function automatic int rb();
    return int'($urandom_range(0, 1));
  endfunction
  function automatic logic [1:0] m_imm(input logic [6:0] o);
    return (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
  endfunction
  // RISC-V ALU operation: only a register-register funct3 000 with bit 30 set is a subtract
  function automatic logic [2:0] m_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction
  function automatic logic [16:0] mk(input int pcw, input int adr, input int mw, input int irw,
                                     input int rs, input int sa, input int sbs, input int alu,
                                     input int rw, input int ill);
    return {pcw[0], adr[0], mw[0], irw[0], rs[1:0], sa[1:0], sbs[1:0], alu[2:0], m_imm(op), rw[0], ill[0]};
  endfunction
  // One clock cycle: drive handshake inputs, record the expected outputs, advance
  task automatic step(input int st, input logic [16:0] ctl, input int mr, input int z, input int retire);
    exp_t e;
    mem_ready = mr[0];
    Zero      = z[0];
    e.st  = st[3:0];
    e.ctl = ctl;
    e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (retire != 0) cnt = cnt + 1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    cnt = 0;
    repeat (n) step(0, mk(0, 0, 0, 0, 2, 0, 2, 0, 0, 0), rb(), rb(), 0);
    rst = 1'b1;
  endtask
  task automatic alu_wb();
    step(8, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), rb(), rb(), 1);
  endtask
  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 random illegal, 7 op 0000000
  task automatic run(input int kind, input int wf, input int wm, input bit abort, input int f3i, input int f7i);
    int nf;
    int nm;
    int z;
    nf = (wf < 0) ? int'($urandom_range(0, 2)) : wf;
    nm = (wm < 0) ? int'($urandom_range(0, 3)) : wm;
    funct3   = (f3i < 0) ? 3'($urandom) : f3i[2:0];
    funct7b5 = (f7i < 0) ? rb() != 0 : f7i[0];
    z        = (f7i < 0) ? rb() : f7i;
    case (kind)
      0: op = LW;
      1: op = SW;
      2: op = RT;
      3: op = IT;
      4: op = BR;
      5: op = JL;
      6: do op = 7'($urandom); while (op inside {LW, SW, RT, IT, BR, JL});
      default: op = 7'b0000000;
    endcase
    repeat (nf) step(0, mk(0, 0, 0, 0, 2, 0, 2, 0, 0, 0), 0, rb(), 0);
    step(0, mk(1, 0, 0, 1, 2, 0, 2, 0, 0, 0), 1, rb(), 0);
    step(1, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, (kind >= 6) ? 1 : 0), rb(), rb(), 0);
    case (kind)
      0: begin
        step(2, mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0), rb(), rb(), 0);
        repeat (nm) step(3, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, rb(), 0);
        step(3, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, rb(), 0);
        step(4, mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0), rb(), rb(), 1);
      end
      1: begin
        step(2, mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0), rb(), rb(), 0);
        repeat (nm) step(5, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, rb(), 0);
        if (abort) do_reset(2);
        else step(5, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, rb(), 1);
      end
      2: begin
        step(6, mk(0, 0, 0, 0, 0, 2, 0, int'(m_alu(op, funct3, funct7b5)), 0, 0), rb(), rb(), 0);
        alu_wb();
      end
      3: begin
        step(7, mk(0, 0, 0, 0, 0, 2, 1, int'(m_alu(op, funct3, funct7b5)), 0, 0), rb(), rb(), 0);
        alu_wb();
      end
      4: step(9, mk(z, 0, 0, 0, 0, 2, 0, 1, 0, 0), rb(), z, 1);
      5: begin
        step(10, mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0), rb(), rb(), 0);
        alu_wb();
      end
      default: ;
    endcase
  endtask
  // Monitor: every cycle the DUT presents a control word; compare it against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    logic [16:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal_instr};
      n_chk++;
      if (state_o !== e.st) begin
        n_fail++;
        $display("FAIL state t=%0t got=%0d expected=%0d", $time, state_o, e.st);
      end
      n_chk++;
      if (got !== e.ctl) begin
        n_fail++;
        $display("FAIL controls t=%0t state=%0d got=%b expected=%b", $time, e.st, got, e.ctl);
      end
      n_chk++;
      if (instret !== e.cnt) begin
        n_fail++;
        $display("FAIL instret t=%0t got=%0d expected=%0d", $time, instret, e.cnt);
      end
    end
  end
  initial begin
    rst       = 1'b0;
    op        = 7'b0;
    funct3    = 3'b0;
    funct7b5  = 1'b0;
    Zero      = 1'b0;
    mem_ready = 1'b1;
    cnt       = 0;
    @(posedge clk);
    #1;
    do_reset(2);
    run(0, 0, 0, 1'b0, -1, -1);
    run(1, 0, 3, 1'b0, -1, -1);
    run(2, 0, 0, 1'b0, 0, 1);
    run(2, 0, 0, 1'b0, 0, 0);
    run(3, 0, 0, 1'b0, 0, 1);
    run(4, 0, 0, 1'b0, -1, 1);
    run(4, 0, 0, 1'b0, -1, 0);
    run(5, 0, 0, 1'b0, -1, -1);
    run(7, 0, 0, 1'b0, -1, -1);
    run(1, 0, 2, 1'b1, -1, -1);
    for (int i = 0; i < 400; i++)
      run(int'($urandom_range(0, 6)), -1, -1, $urandom_range(0, 19) == 0, -1, -1);
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
